// File: rtl/radio_timing_pkg.sv
// Shared types and defaults for the radio timing sequencer.
// Slot phases and the counter width / guard length used by the FSM.
package radio_timing_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACTIVE,
    GUARD
  } rt_state_t;

  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned OFF_GUARD_DEF = 4;

endpackage

// File: rtl/radio_seq_cnt.sv
// Loadable down-counter shared by the settle, active and guard phases.
// Holds at zero; a load overrides counting.
module radio_seq_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             ck,
  input  logic             arst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  assign zero = (value == '0);

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (!zero) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/radio_timing_sequencer.sv
// Radio enable / RX enable slot sequencer: settle, active window, guard.
// Drives radioEnable1 / radioRxEn1 of the TimingEngine radio path.
module radio_timing_sequencer
  import radio_timing_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned OFF_GUARD = OFF_GUARD_DEF
) (
  input  logic             ck,
  input  logic             arst_n,
  input  logic             start,
  input  logic             rx_not_tx,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0] active_cycles,
  input  logic             abort,
  output logic             radio_enable1,
  output logic             radio_rx_en1,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             start_err
);

  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(OFF_GUARD - 1);

  rt_state_t        state;
  rt_state_t        nxt;
  logic             rx_lat;
  logic [CNT_W-1:0] act_lat;
  logic             abort_flag;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_ld_val;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             en_d;
  logic             rx_d;
  logic             done_d;
  logic             abt_d;
  logic             err_d;
  logic             abort_hit;

  radio_seq_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .ck      (ck),
    .arst_n  (arst_n),
    .load    (cnt_load),
    .load_val(cnt_ld_val),
    .value   (cnt_value),
    .zero    (cnt_zero)
  );

  assign accept    = (state == IDLE) && start && !abort;
  assign abort_hit = abort && ((state == SETTLE) || (state == ACTIVE));

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt        = state;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          nxt        = SETTLE;
          cnt_load   = 1'b1;
          cnt_ld_val = (settle_cycles == '0) ? '0
                                             : settle_cycles - 1'b1;
        end
      end
      SETTLE: begin
        if (abort || (cnt_zero && act_lat == '0)) begin
          nxt        = GUARD;
          cnt_load   = 1'b1;
          cnt_ld_val = GUARD_LD;
        end else if (cnt_zero) begin
          nxt        = ACTIVE;
          cnt_load   = 1'b1;
          cnt_ld_val = act_lat - 1'b1;
        end
      end
      ACTIVE: begin
        if (abort || cnt_zero) begin
          nxt        = GUARD;
          cnt_load   = 1'b1;
          cnt_ld_val = GUARD_LD;
        end
      end
      GUARD: begin
        if (cnt_zero) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they change at the same edge.
  always_comb begin
    en_d   = (nxt != IDLE);
    rx_d   = (nxt == ACTIVE) && rx_lat;
    done_d = (state == GUARD) && cnt_zero;
    abt_d  = done_d && abort_flag;
    err_d  = start && (state != IDLE);
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      rx_lat     <= 1'b0;
      act_lat    <= '0;
      abort_flag <= 1'b0;
    end else if (accept) begin
      rx_lat     <= rx_not_tx;
      act_lat    <= active_cycles;
      abort_flag <= 1'b0;
    end else if (abort_hit) begin
      abort_flag <= 1'b1;
    end
  end

  always_ff @(posedge ck or negedge arst_n) begin
    if (!arst_n) begin
      radio_enable1 <= 1'b0;
      radio_rx_en1  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      start_err     <= 1'b0;
    end else begin
      radio_enable1 <= en_d;
      radio_rx_en1  <= rx_d;
      busy          <= en_d;
      done          <= done_d;
      aborted       <= abt_d;
      start_err     <= err_d;
    end
  end

endmodule

// File: tb/tb_radio_timing_sequencer.sv
// Bench for radio_timing_sequencer: directed slots then random traffic.
// Expected outputs come from a per-slot timeline model (edge numbers).
module tb_radio_timing_sequencer;

  localparam int G = 4;

  logic        ck = 1'b0;
  logic        arst_n;
  logic        start;
  logic        rx_not_tx;
  logic [15:0] settle_cycles;
  logic [15:0] active_cycles;
  logic        abort;
  logic        radio_enable1;
  logic        radio_rx_en1;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        start_err;

  int n_checks = 0;
  int n_err    = 0;

  int cyc = 0;
  int slot_e, t_act, t_guard, t_end;
  bit have = 0;
  bit rxl  = 0;
  bit abd  = 0;

  always #5 ck = ~ck;

  radio_timing_sequencer #(
    .CNT_W    (16),
    .OFF_GUARD(G)
  ) dut (
    .ck           (ck),
    .arst_n       (arst_n),
    .start        (start),
    .rx_not_tx    (rx_not_tx),
    .settle_cycles(settle_cycles),
    .active_cycles(active_cycles),
    .abort        (abort),
    .radio_enable1(radio_enable1),
    .radio_rx_en1 (radio_rx_en1),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .start_err    (start_err)
  );

  task automatic chk(string tag, logic obs, logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(bit en, bit rx, bit dn, bit ab, bit er);
    chk("radio_enable1", radio_enable1, en);
    chk("radio_rx_en1", radio_rx_en1, rx);
    chk("busy", busy, en);
    chk("done", done, dn);
    chk("aborted", aborted, ab);
    chk("start_err", start_err, er);
    n_checks++;
    assert (!(radio_rx_en1 && !radio_enable1))
    else begin
      n_err++;
      $error("FAIL rx_implies_en cyc=%0d observed=%b expected=0",
             cyc, radio_rx_en1);
    end
  endtask

  task automatic step(bit st, bit rx, int s, int a, bit ab);
    bit busy_pre, e_err, e_en, e_rx, e_dn;
    int sl;
    @(negedge ck);
    start         = st;
    rx_not_tx     = rx;
    settle_cycles = 16'(s);
    active_cycles = 16'(a);
    abort         = ab;
    @(posedge ck);
    cyc++;
    busy_pre = have && (slot_e < cyc) && (cyc <= t_end);
    e_err    = st && busy_pre;
    if (ab && busy_pre && cyc <= t_guard) begin
      t_guard = cyc;
      t_end   = cyc + G;
      abd     = 1;
    end else if (st && !ab && !busy_pre) begin
      sl      = (s == 0) ? 1 : s;
      have    = 1;
      slot_e  = cyc;
      rxl     = rx;
      abd     = 0;
      t_act   = cyc + sl;
      t_guard = t_act + a;
      t_end   = t_guard + G;
    end
    e_en = have && (slot_e <= cyc) && (cyc < t_end);
    e_rx = have && rxl && (t_act <= cyc) && (cyc < t_guard);
    e_dn = have && (cyc == t_end);
    #1;
    chk_all(e_en, e_rx, e_dn, e_dn && abd, e_err);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    #1 arst_n = 1'b0;
    #1 chk_all(0, 0, 0, 0, 0);
    have = 0;
    #1 arst_n = 1'b1;
  endtask

  initial begin
    arst_n        = 1'b0;
    start         = 1'b0;
    rx_not_tx     = 1'b0;
    settle_cycles = '0;
    active_cycles = '0;
    abort         = 1'b0;
    #12;
    chk_all(0, 0, 0, 0, 0);
    @(negedge ck);
    arst_n = 1'b1;

    idle(3);
    step(1, 1, 3, 5, 0);
    idle(14);
    step(1, 0, 3, 5, 0);
    idle(14);
    step(1, 1, 0, 0, 0);
    idle(7);

    step(1, 1, 2, 100, 0);
    idle(9);
    step(0, 0, 0, 0, 1);
    idle(7);

    step(1, 1, 3, 5, 0);
    idle(4);
    step(1, 0, 9, 9, 0);
    idle(14);
    step(1, 1, 1, 1, 1);
    idle(3);

    step(1, 1, 1, 20, 0);
    idle(5);
    do_reset();
    idle(2);
    step(1, 1, 2, 3, 0);
    idle(9);

    step(1, 1, 1, 2, 0);
    idle(7);
    step(1, 0, 0, 1, 0);
    idle(6);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 7) == 0, 1'($urandom),
           $urandom_range(0, 6), $urandom_range(0, 10),
           $urandom_range(0, 29) == 0);
    end
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
